// File: rtl/rtype_exec_if.sv
//------------------------------------------------------------------------------
// Module      : rtype_exec_if
// Description : Bundle between the R-type execute sequencer and its
//               neighbours: the decode handshake, the regfile read/write
//               ports, and the alucontrol/alu operand and result lines.
//               slave  = the sequencer, master = the surrounding datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rtype_exec_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  // decode handshake
  logic               instr_valid;
  logic               instr_ready;
  logic [REGBITS-1:0] rs;
  logic [REGBITS-1:0] rt;
  logic [REGBITS-1:0] rd;
  logic [5:0]         funct;
  // regfile read port
  logic [REGBITS-1:0] ra1;
  logic [REGBITS-1:0] ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  // alucontrol / alu
  logic [1:0]         aluop;
  logic [5:0]         alu_funct;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   result;
  // regfile write port
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic               regwrite;
  // retirement status
  logic               done;
  logic               err;

  modport slave (
    input  instr_valid, rs, rt, rd, funct, rd1, rd2, result,
    output instr_ready, ra1, ra2, aluop, alu_funct, a, b, wa, wd,
           regwrite, done, err
  );

  modport master (
    output instr_valid, rs, rt, rd, funct, rd1, rd2, result,
    input  instr_ready, ra1, ra2, aluop, alu_funct, a, b, wa, wd,
           regwrite, done, err
  );
endinterface

`default_nettype wire

// File: rtl/rtype_exec.sv
//------------------------------------------------------------------------------
// Module      : rtype_exec
// Description : Multicycle R-type execute sequencer for the 8-bit TinyMIPS
//               datapath. Accepts one decoded instruction, reads both
//               operands from the regfile, runs them through the ALU and
//               writes the result back to rd.
//               Sequence: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtype_exec #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  rtype_exec_if.slave  bus
);

  // alucontrol decodes by funct when aluop is 2'b10
  localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] C_FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] C_FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] C_FUNCT_AND   = 6'b100100;
  localparam logic [5:0] C_FUNCT_OR    = 6'b100101;
  localparam logic [5:0] C_FUNCT_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  // fields captured at the acceptance edge, stable until DONE
  logic [REGBITS-1:0] r_rs;
  logic [REGBITS-1:0] r_rt;
  logic [REGBITS-1:0] r_rd;
  logic [5:0]         r_funct;
  // operand and result registers
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_result;
  logic [REGBITS-1:0] r_wa;
  // registered status pulses
  logic               r_regwrite;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_supported;

  function automatic logic funct_supported(input logic [5:0] f);
    logic ok;
    case (f)
      C_FUNCT_ADD,
      C_FUNCT_SUB,
      C_FUNCT_AND,
      C_FUNCT_OR,
      C_FUNCT_SLT: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // decoded from the captured funct so late input changes cannot leak in
  assign w_supported = funct_supported(r_funct);
  assign w_accept    = (r_state == S_IDLE) && bus.instr_valid;

  // sequencer: state, captured fields, operands, result and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_wa       <= '0;
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // single-cycle pulses default low
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rs    <= bus.rs;
            r_rt    <= bus.rt;
            r_rd    <= bus.rd;
            r_funct <= bus.funct;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // latched before any write, so rd == rs/rt is safe
          r_opa   <= bus.rd1;
          r_opb   <= bus.rd2;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result   <= bus.result;
          r_wa       <= r_rd;
          r_regwrite <= w_supported && (r_rd != '0);
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_done  <= 1'b1;
          r_err   <= ~w_supported;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ready is a state decode, gated so it stays low while reset is held
  assign bus.instr_ready = (r_state == S_IDLE) && reset_n;

  assign bus.ra1       = r_rs;
  assign bus.ra2       = r_rt;
  assign bus.aluop     = C_ALUOP_RTYPE;
  assign bus.alu_funct = r_funct;
  assign bus.a         = r_opa;
  assign bus.b         = r_opb;
  assign bus.wa        = r_wa;
  assign bus.wd        = r_result;
  assign bus.regwrite  = r_regwrite;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rtype_exec.sv
//------------------------------------------------------------------------------
// Module      : tb_rtype_exec
// Description : Bench for rtype_exec with a behavioural regfile/ALU around
//               the block and an architectural register model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rtype_exec;
  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rtype_exec_if #(.WIDTH(WIDTH), .REGBITS(REGBITS)) bus ();

  rtype_exec #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // environment regfile: bench write port muxed ahead of the block's
  logic [WIDTH-1:0] mem [0:7];
  logic             tb_we;
  logic [2:0]       tb_wa;
  logic [7:0]       tb_wd;

  assign bus.rd1 = (bus.ra1 == 3'd0) ? 8'd0 : mem[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 3'd0) ? 8'd0 : mem[bus.ra2];

  // regfile write port
  always @(posedge clk) begin
    if (tb_we) begin
      if (tb_wa != 3'd0) mem[tb_wa] <= tb_wd;
    end else if (bus.regwrite && bus.wa != 3'd0) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // environment alucontrol + alu
  always_comb begin
    bus.result = 8'd0;
    if (bus.aluop == 2'b10) begin
      case (bus.alu_funct)
        6'b100000: bus.result = bus.a + bus.b;
        6'b100010: bus.result = bus.a - bus.b;
        6'b100100: bus.result = bus.a & bus.b;
        6'b100101: bus.result = bus.a | bus.b;
        6'b101010: bus.result = ($signed(bus.a) < $signed(bus.b)) ? 8'd1 : 8'd0;
        default:   bus.result = 8'd0;
      endcase
    end
  end

  // architectural model
  int unsigned exp_regs [8];
  int          checks = 0;
  int          errors = 0;

  function automatic bit is_sup(int f);
    return (f == 32) || (f == 34) || (f == 36) || (f == 37) || (f == 42);
  endfunction

  function automatic int to_signed8(int unsigned x);
    return (x >= 128) ? int'(x) - 256 : int'(x);
  endfunction

  function automatic int unsigned ref_alu(int f, int unsigned x, int unsigned y);
    case (f)
      32:      return (x + y) % 256;
      34:      return (x + 256 - y) % 256;
      36:      return x & y;
      37:      return x | y;
      42:      return (to_signed8(x) < to_signed8(y)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(int i);
    return (i == 0) ? 32'd0 : 32'(mem[i]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] r, input logic [7:0] v);
    tb_we = 1'b1;
    tb_wa = r;
    tb_wd = v;
    @(posedge clk);
    @(negedge clk);
    tb_we = 1'b0;
    if (r != 3'd0) exp_regs[r] = 32'(v);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_ra1"},       32'(bus.ra1), 0);
    check({pfx, "_ra2"},       32'(bus.ra2), 0);
    check({pfx, "_a"},         32'(bus.a), 0);
    check({pfx, "_b"},         32'(bus.b), 0);
    check({pfx, "_wa"},        32'(bus.wa), 0);
    check({pfx, "_wd"},        32'(bus.wd), 0);
    check({pfx, "_alu_funct"}, 32'(bus.alu_funct), 0);
    check({pfx, "_regwrite"},  32'(bus.regwrite), 0);
    check({pfx, "_done"},      32'(bus.done), 0);
    check({pfx, "_err"},       32'(bus.err), 0);
  endtask

  task automatic readback_model(input string pfx);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", pfx, i), rf_read(i), exp_regs[i]);
  endtask

  // one instruction, starting and ending just after a falling edge;
  // hold keeps instr_valid high with junk fields while busy
  task automatic run_instr(input logic [2:0] s, input logic [2:0] t,
                           input logic [2:0] d, input logic [5:0] f,
                           input bit hold);
    int unsigned opa, opb, res;
    bit          sup, we;
    int          n;
    logic [31:0] rnd;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(bus.instr_ready), 1);
    opa = (s == 3'd0) ? 0 : exp_regs[s];
    opb = (t == 3'd0) ? 0 : exp_regs[t];
    sup = is_sup(int'(f));
    res = ref_alu(int'(f), opa, opb);
    we  = sup && (d != 3'd0);
    bus.instr_valid = 1'b1;
    bus.rs = s;
    bus.rt = t;
    bus.rd = d;
    bus.funct = f;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        rnd = $urandom;
        bus.rs = rnd[2:0];
        bus.rt = rnd[5:3];
        bus.rd = rnd[8:6];
        bus.funct = rnd[14:9];
        bus.instr_valid = hold;
      end
      check($sformatf("ready_c%0d", k),    32'(bus.instr_ready), (k == 5) ? 1 : 0);
      check($sformatf("regwrite_c%0d", k), 32'(bus.regwrite), (k == 3) ? 32'(we) : 0);
      check($sformatf("done_c%0d", k),     32'(bus.done), (k == 4) ? 1 : 0);
      check($sformatf("err_c%0d", k),      32'(bus.err), (k == 4 && !sup) ? 1 : 0);
      if (k == 1) begin
        check("read_ra1", 32'(bus.ra1), 32'(s));
        check("read_ra2", 32'(bus.ra2), 32'(t));
      end
      if (k == 2) begin
        check("exec_a",         32'(bus.a), opa);
        check("exec_b",         32'(bus.b), opb);
        check("exec_alu_funct", 32'(bus.alu_funct), 32'(f));
        check("exec_aluop",     32'(bus.aluop), 2);
      end
      if (k == 3) begin
        check("write_wa", 32'(bus.wa), 32'(d));
        if (sup) check("write_wd", 32'(bus.wd), res);
      end
    end
    if (we) exp_regs[d] = res;
  endtask

  // hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  golden [8];
  logic [5:0]  ftab   [6];
  logic [31:0] rnd;
  logic [5:0]  f;

  initial begin
    golden = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255, 8'd0, 8'd3, 8'd1};
    ftab   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int i = 0; i < 8; i++) exp_regs[i] = 0;
    reset_n = 1'b0;
    tb_we = 1'b0;
    tb_wa = 3'd0;
    tb_wd = 8'd0;
    bus.instr_valid = 1'b0;
    bus.rs = 3'd0;
    bus.rt = 3'd0;
    bus.rd = 3'd0;
    bus.funct = 6'd0;

    // reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_ready_low", 32'(bus.instr_ready), 0);
    reset_n = 1'b1;
    #1;
    check("reset_ready_after_release", 32'(bus.instr_ready), 1);
    @(negedge clk);
    for (int i = 1; i < 8; i++) preload(3'(i), 8'd0);

    // ALU scenarios
    preload(3'd1, 8'd1);
    preload(3'd2, 8'd2);
    run_instr(3'd1, 3'd2, 3'd3, 6'b100000, 1'b0);
    run_instr(3'd1, 3'd2, 3'd4, 6'b100010, 1'b0);
    run_instr(3'd1, 3'd2, 3'd5, 6'b100100, 1'b0);
    run_instr(3'd1, 3'd2, 3'd6, 6'b100101, 1'b0);
    run_instr(3'd1, 3'd2, 3'd7, 6'b101010, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("alu_golden_r%0d", i), rf_read(i), 32'(golden[i]));
    readback_model("alu");

    // hazard: dependent instruction sees the new r1
    run_instr(3'd1, 3'd2, 3'd1, 6'b100000, 1'b0);
    run_instr(3'd1, 3'd1, 3'd3, 6'b100000, 1'b0);
    check("hazard_r1", rf_read(1), 3);
    check("hazard_r3", rf_read(3), 6);

    // unsupported funct and zero destination
    run_instr(3'd1, 3'd2, 3'd5, 6'b000000, 1'b0);
    readback_model("illegal");
    run_instr(3'd1, 3'd2, 3'd0, 6'b100000, 1'b0);
    check("rd0_r0", rf_read(0), 0);

    // reset during EXEC drops the instruction
    bus.rs = 3'd1;
    bus.rt = 3'd2;
    bus.rd = 3'd4;
    bus.funct = 6'b100010;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("midop_exec_a", 32'(bus.a), exp_regs[1]);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midop");
    check("midop_ready_low", 32'(bus.instr_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check("midop_regwrite_held", 32'(bus.regwrite), 0);
    reset_n = 1'b1;
    #1;
    check("midop_ready_after_release", 32'(bus.instr_ready), 1);
    check("midop_r4_unchanged", rf_read(4), exp_regs[4]);
    run_instr(3'd1, 3'd2, 3'd4, 6'b100010, 1'b0);
    check("midop_next_r4", rf_read(4), exp_regs[4]);

    // back-to-back acceptance with instr_valid held high
    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      run_instr(rnd[2:0], rnd[5:3], rnd[8:6], ftab[rnd[31:29] % 5], 1'b1);
    end
    bus.instr_valid = 1'b0;
    readback_model("b2b");

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      rnd = $urandom;
      if (rnd[20:18] == 3'd0) preload(rnd[2:0], rnd[15:8]);
      rnd = $urandom;
      f = (rnd[31:29] % 6 == 5) ? rnd[17:12] : ftab[rnd[31:29] % 6];
      run_instr(rnd[2:0], rnd[5:3], rnd[8:6], f, rnd[24]);
      bus.instr_valid = 1'b0;
    end
    readback_model("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
